// File: rtl/lbdr_dr_if.sv
// Flit type encoding shared by the route unit and its environment, plus the
// interface bundling the FIFO side, configuration inputs and port requests.
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

// Handshake: a flit is presented by the FIFO side and consumed on every
// rising clk edge where empty=0; there is no backpressure toward the FIFO.
interface lbdr_dr_if #(
    parameter int AW = 4
);
    logic          empty;
    logic [2:0]    flit_id;
    logic [AW-1:0] dst_addr;
    logic [7:0]    Rxy_rst;
    logic [3:0]    Cx_rst;
    logic [1:0]    dr_rst;
    logic [AW-1:0] cur_addr_rst;
    logic          Nport;
    logic          Eport;
    logic          Wport;
    logic          Sport;
    logic          Lport;
    logic          pkt_active;
    logic          err_unroutable;
    logic          err_proto;
    logic [1:0]    state_dbg;

    modport master (
        output empty, flit_id, dst_addr, Rxy_rst, Cx_rst, dr_rst, cur_addr_rst,
        input  Nport, Eport, Wport, Sport, Lport, pkt_active, err_unroutable,
               err_proto, state_dbg
    );

    modport slave (
        input  empty, flit_id, dst_addr, Rxy_rst, Cx_rst, dr_rst, cur_addr_rst,
        output Nport, Eport, Wport, Sport, Lport, pkt_active, err_unroutable,
               err_proto, state_dbg
    );
endinterface

// File: rtl/lbdr_dr.sv
// LBDR route computation for one router input port: minimal routing with
// deroute fallback and optional fork, route held from HEADER through TAIL.
module lbdr_dr #(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter bit DEROUTE_EN = 1'b1,
    parameter bit FORK_EN    = 1'b0
) (
    input logic       clk,
    input logic       rst,
    lbdr_dr_if.slave  bus
);
    localparam int AW = X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LAST   = 2'd2
    } state_t;

    // Port vector layout: {N, E, W, S, L}
    localparam logic [4:0] P_N = 5'b10000;
    localparam logic [4:0] P_E = 5'b01000;
    localparam logic [4:0] P_W = 5'b00100;
    localparam logic [4:0] P_S = 5'b00010;
    localparam logic [4:0] P_L = 5'b00001;

    logic [7:0]    rxy_q;
    logic [3:0]    cx_q;
    logic [1:0]    dr_q;
    logic [AW-1:0] cur_q;

    state_t     state_q, state_n;
    logic [4:0] ports_q, ports_n;
    logic       eu_q, eu_n;
    logic       ep_q, ep_n;

    // Configuration is captured every cycle reset is held, frozen afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxy_q <= bus.Rxy_rst;
            cx_q  <= bus.Cx_rst;
            dr_q  <= bus.dr_rst;
            cur_q <= bus.cur_addr_rst;
        end
    end

    logic [X_W-1:0] x_dst, x_cur;
    logic [Y_W-1:0] y_dst, y_cur;
    assign x_dst = bus.dst_addr[X_W-1:0];
    assign y_dst = bus.dst_addr[AW-1:X_W];
    assign x_cur = cur_q[X_W-1:0];
    assign y_cur = cur_q[AW-1:X_W];

    logic n1, s1, e1, w1;
    assign n1 = (y_dst < y_cur);
    assign s1 = (y_dst > y_cur);
    assign e1 = (x_dst > x_cur);
    assign w1 = (x_dst < x_cur);

    // Routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, connectivity {Cs,Cw,Ce,Cn}
    logic r_ne, r_nw, r_en, r_es, r_wn, r_ws, r_se, r_sw;
    logic c_n, c_e, c_w, c_s;
    assign {r_sw, r_se, r_ws, r_wn, r_es, r_en, r_nw, r_ne} = rxy_q;
    assign {c_s, c_w, c_e, c_n} = cx_q;

    logic       min_n, min_e, min_w, min_s, min_l;
    logic [4:0] route;

    // Route for the flit currently on dst_addr; all-zero means unroutable.
    always_comb begin
        min_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & r_ne) | (n1 & w1 & r_nw)) & c_n;
        min_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & r_en) | (e1 & s1 & r_es)) & c_e;
        min_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & r_wn) | (w1 & s1 & r_ws)) & c_w;
        min_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & r_se) | (s1 & w1 & r_sw)) & c_s;
        min_l = ~n1 & ~e1 & ~w1 & ~s1;
        route = 5'b0;
        if (min_l) begin
            route = P_L;
        end else if (min_n | min_e | min_w | min_s) begin
            if (FORK_EN)     route = {min_n, min_e, min_w, min_s, 1'b0};
            else if (min_n)  route = P_N;
            else if (min_e)  route = P_E;
            else if (min_w)  route = P_W;
            else             route = P_S;
        end else if (DEROUTE_EN) begin
            case (dr_q)
                2'b00:   route = c_n ? P_N : 5'b0;
                2'b01:   route = c_e ? P_E : 5'b0;
                2'b10:   route = c_w ? P_W : 5'b0;
                default: route = c_s ? P_S : 5'b0;
            endcase
        end
    end

    logic valid, is_hdr, is_body, is_tail;
    assign valid   = ~bus.empty;
    assign is_hdr  = (bus.flit_id == `HEADER);
    assign is_body = (bus.flit_id == `BODY);
    assign is_tail = (bus.flit_id == `TAIL);

    // Packet FSM: next state, next port vector and error pulses.
    always_comb begin
        state_n = state_q;
        ports_n = ports_q;
        eu_n    = 1'b0;
        ep_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && is_hdr) begin
                    ports_n = route;
                    eu_n    = ~|route;
                    state_n = (|route) ? ACTIVE : IDLE;
                end else if (valid) begin
                    ep_n    = 1'b1;
                    ports_n = 5'b0;
                end
            end
            ACTIVE: begin
                if (valid && is_hdr) begin
                    ep_n    = 1'b1;
                    ports_n = route;
                    eu_n    = ~|route;
                    state_n = (|route) ? ACTIVE : IDLE;
                end else if (valid && is_tail) begin
                    state_n = LAST;
                end else if (valid && !is_body) begin
                    ep_n = 1'b1;
                end
            end
            LAST: begin
                if (valid && is_hdr) begin
                    ports_n = route;
                    eu_n    = ~|route;
                    state_n = (|route) ? ACTIVE : IDLE;
                end else begin
                    ports_n = 5'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                ports_n = 5'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset also drops any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ports_q <= 5'b0;
            eu_q    <= 1'b0;
            ep_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            ports_q <= ports_n;
            eu_q    <= eu_n;
            ep_q    <= ep_n;
        end
    end

    assign {bus.Nport, bus.Eport, bus.Wport, bus.Sport, bus.Lport} = ports_q;
    assign bus.pkt_active     = (state_q != IDLE);
    assign bus.err_unroutable = eu_q;
    assign bus.err_proto      = ep_q;
    assign bus.state_dbg      = state_q;
endmodule
